sump3_lb_master: RTL

SUMP3_LB_MASTER -- requirements
Module: sump3_lb_master

---
 rtl/sump3_lb_master.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sump3_lb_master.sv
// ---------------------------------------------------------------------------
// sump3_lb_master
//
// Converts single request/response commands into local-bus strobes for the
// sump3 core. The block accepts one command at a time, drives the chip
// select and read/write strobe for exactly one cycle, and then either
// returns at once (write) or waits for lb_rd_rdy (read). A read that gets
// no lb_rd_rdy within TIMEOUT_CYCLES returns TIMEOUT_DATA with rsp_timeout
// set. Every output comes straight from a flop.
//
// Parameters
//   TIMEOUT_CYCLES  cycles waited for lb_rd_rdy after a read strobe (1..65535)
//   TIMEOUT_DATA    read data returned when a read times out
//
// Ports
//   clk_lb          single clock, rising edge
//   reset           synchronous active-high reset
//   cmd_valid/ready command handshake; cmd_wr 1=write, cmd_sel 0=ctrl 1=data
//   cmd_wdata       write data for the command
//   rsp_valid/ready response handshake
//   rsp_rdata       read data (0 for writes), rsp_timeout read timed out
//   lb_cs_ctrl/data local-bus chip selects
//   lb_wr/lb_rd     local-bus write/read strobes, lb_wr_d write data
//   lb_rd_d         local-bus read data, lb_rd_rdy read data valid
// ---------------------------------------------------------------------------
module sump3_lb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic        cmd_sel,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        lb_cs_ctrl,
  output logic        lb_cs_data,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic        sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        cs_ctrl_q, cs_ctrl_d;
  logic        cs_data_q, cs_data_d;
  logic        lbwr_q, lbwr_d;
  logic        lbrd_q, lbrd_d;
  logic [31:0] lb_wdata_q, lb_wdata_d;

  assign cnt_inc = cnt_q + 16'd1;

  // Next-state logic. lb_rd_rdy is only looked at in a read ISSUE or in
  // WAIT, so stray pulses anywhere else cannot disturb the response. In WAIT
  // the ready check comes before the timeout check so a coincident ready wins.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_wr;
          sel_d   = cmd_sel;
          wdata_d = cmd_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          rdata_d   = 32'd0;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (lb_rd_rdy) begin
          rdata_d   = lb_rd_d;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d   = 16'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (lb_rd_rdy) begin
          rdata_d   = lb_rd_d;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_inc == TimeoutCnt) begin
          rdata_d   = TIMEOUT_DATA;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values are decoded from the next state so that the flops below
  // present them in the same cycle the FSM enters that state.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    cs_ctrl_d   = (state_d == ISSUE) && !sel_d;
    cs_data_d   = (state_d == ISSUE) && sel_d;
    lbwr_d      = (state_d == ISSUE) && wr_d;
    lbrd_d      = (state_d == ISSUE) && !wr_d;
    lb_wdata_d  = ((state_d == ISSUE) && wr_d) ? wdata_d : 32'd0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_lb) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      sel_q       <= 1'b0;
      wdata_q     <= 32'd0;
      cnt_q       <= 16'd0;
      rdata_q     <= 32'd0;
      timeout_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cs_ctrl_q   <= 1'b0;
      cs_data_q   <= 1'b0;
      lbwr_q      <= 1'b0;
      lbrd_q      <= 1'b0;
      lb_wdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      cs_ctrl_q   <= cs_ctrl_d;
      cs_data_q   <= cs_data_d;
      lbwr_q      <= lbwr_d;
      lbrd_q      <= lbrd_d;
      lb_wdata_q  <= lb_wdata_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_timeout = timeout_q;
  assign lb_cs_ctrl  = cs_ctrl_q;
  assign lb_cs_data  = cs_data_q;
  assign lb_wr       = lbwr_q;
  assign lb_rd       = lbrd_q;
  assign lb_wr_d     = lb_wdata_q;

endmodule
